execute_cycle: RTL and testbench
================================

# execute_cycle

Execute stage of the five-stage RISC-V pipeline. Consumes the ID/EX pipeline register contents produced by the decode stage. Applies operand forwarding, runs the ALU, and resolves conditional branches (PCSrcE/PCTargetE back to fetch). Captures results into the EX/MEM pipeline register, which supports hold (stall) and bubble insertion.

## Interface
Parameters:
- none; all widths fixed at RV32 (XLEN = 32, register index 5 bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- ValidE  in  1  ID/EX slot holds a real instruction; 0 = bubble.
- RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE  in  1 each  ID/EX control bits.
- ALUControlE  in  3  ALU op.
- Funct3E  in  3  branch condition select.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  32 each  ID/EX data.
- RDE  in  5  destination register.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- ResultW  in  32  writeback result, used for forwarding.
- StallM  in  1  hold EX/MEM register contents.
- PCSrcE  out  1  branch taken (combinational).
- PCTargetE  out  32  PCE + ImmExtE (combinational).
- ValidM, RegWriteM, ResultSrcM, MemWriteM  out  1 each  EX/MEM control bits.
- ALUResultM, WriteDataM, PCPlus4M  out  32 each  EX/MEM data.
- RDM  out  5  EX/MEM destination register.

## Operation
- Forward mux, applied separately to each operand:
  - Sel 00 → RD1E/RD2E; 01 → ResultW; 10 → ALUResultM (the internal registered value); 11 → same as 00.
  - Result: SrcAE from forward A; FwdBE from forward B.
- SrcBE = ALUSrcE ? ImmExtE : FwdBE. WriteDataE = FwdBE.
- ALU ops:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 slt, signed, result 0/1 zero-extended.
  - 110 sltu; 111 sll using SrcBE[4:0].
  - add/sub wrap modulo 2^32; no overflow flag.
- Branch comparator on SrcAE vs FwdBE, independent of ALUControlE. Conditions by Funct3E:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011 never taken.
- PCSrcE = ValidE & BranchE & cond. Asserted regardless of StallM; the hazard unit owns the stall/flush interplay.
- EX/MEM register, priority rst > StallM > capture:
  - rst: all outputs 0.
  - StallM: all outputs hold.
  - else, ValidE=1: capture ValidM=1, the control bits, ALUResult, WriteDataE, PCPlus4E, RDE.
  - else, ValidE=0: capture ValidM=0 with RegWriteM=MemWriteM=ResultSrcM=0. Data fields are captured unchanged; they are don't-care but deterministic.

## Timing
- Reset values:
  - ValidM, RegWriteM, ResultSrcM, MemWriteM = 0.
  - ALUResultM, WriteDataM, PCPlus4M = 0; RDM = 0.
- rst asserted mid-stream clears the register on that edge, overriding StallM. Combinational outputs still follow their inputs during reset.
- Latency: ID/EX inputs appear on EX/MEM outputs 1 cycle later, at the next rising edge with StallM=0.
- PCSrcE/PCTargetE: 0-cycle combinational path; fetch samples them on the same edge.
- ForwardAE=10 uses the value visible on ALUResultM before the edge. Back-to-back dependent ALU ops therefore need no stall.
- StallM held for N cycles keeps outputs frozen N cycles. The ALU keeps evaluating its current inputs; nothing is lost inside this block because upstream is also stalled.
- Bubble (ValidE=0) never asserts PCSrcE, RegWriteM or MemWriteM.

## Structure
- Shared package riscv_pkg holds:
  - ALU op localparams (ALU_ADD..ALU_SLL);
  - branch funct3 codes (F3_BEQ..F3_BGEU);
  - forward select codes (FWD_RF = 00, FWD_W = 01, FWD_M = 10).
- One sub-module: alu. It is combinational: SrcA, SrcB, ALUControl → Result, Zero.
- Forward muxes, branch comparator, target adder and EX/MEM register stay in execute_cycle.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs → all EX/MEM outputs 0. Release, then ADD with RD1E=5, RD2E=7, ValidE=1 → next cycle ALUResultM=12, RegWriteM=1, ValidM=1.
- Forwarding:
  - Cycle n: ADD → ALUResultM=12.
  - Cycle n+1: SUB, ForwardAE=10, RD2E=20 → ALUResultM = 0xFFFFFFF8.
  - ForwardBE=01 with ResultW=3 and ALUSrcE=0 → B operand 3; WriteDataM=3.
- Branches, PCE=0x100, ImmExtE=0xFFFFFFF0 → PCTargetE=0xF0:
  - BLT SrcA=0xFFFFFFFF, B=1 → PCSrcE=1.
  - BLTU, same operands → PCSrcE=0.
  - BNE, equal operands → PCSrcE=0.
  - ValidE=0 with BEQ equal → PCSrcE=0.
- Stall: set StallM=1 for 3 cycles while inputs change → outputs frozen. On release, the following edge captures the current inputs.
- Bubble: ValidE=0 with RegWriteE=MemWriteE=1 → RegWriteM=MemWriteM=0, ValidM=0.
- Reset priority: rst=1 together with StallM=1 while outputs are nonzero → outputs 0 on that edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute stage: ALU op codes, branch funct3
// codes, forwarding selects and the EX/MEM pipeline register layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             regWrite;
    logic             resultSrc;
    logic             memWrite;
    logic [XLEN-1:0]  aluResult;
    logic [XLEN-1:0]  writeData;
    logic [XLEN-1:0]  pcPlus4;
    logic [4:0]       rd;
  } exMem_t;

  // Select 11 is unused by the hazard unit and falls back to the register file.
  function automatic logic [XLEN-1:0] fwdSelect(input logic [1:0] sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
    case (sel)
      FWD_W:   return wb;
      FWD_M:   return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_cycle_if.sv
// ID/EX inputs, forwarding/stall controls, branch outputs and EX/MEM outputs
// of the execute stage. slave = execute stage, master = surrounding pipeline.
interface execute_cycle_if;
  logic        ValidE;
  logic        RegWriteE;
  logic        ResultSrcE;
  logic        MemWriteE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RDE;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic        StallM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        ValidM;
  logic        RegWriteM;
  logic        ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RDM;

  modport slave (
    input  ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE,
    input  ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
    input  ForwardAE, ForwardBE, ResultW, StallM,
    output PCSrcE, PCTargetE,
    output ValidM, RegWriteM, ResultSrcM, MemWriteM,
    output ALUResultM, WriteDataM, PCPlus4M, RDM
  );

  modport master (
    output ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE,
    output ALUControlE, Funct3E, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE,
    output ForwardAE, ForwardBE, ResultW, StallM,
    input  PCSrcE, PCTargetE,
    input  ValidM, RegWriteM, ResultSrcM, MemWriteM,
    input  ALUResultM, WriteDataM, PCPlus4M, RDM
  );
endinterface

// File: rtl/execute_cycle_alu.sv
// Combinational RV32 ALU: add/sub wrap modulo 2^32, set-less-than results are
// zero-extended 0/1, shift amount is SrcB[4:0].
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic ltSigned;
  logic ltUnsigned;

  assign ltSigned   = $signed(SrcA) < $signed(SrcB);
  assign ltUnsigned = SrcA < SrcB;

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:  Result = SrcA + SrcB;
      ALU_SUB:  Result = SrcA - SrcB;
      ALU_AND:  Result = SrcA & SrcB;
      ALU_OR:   Result = SrcA | SrcB;
      ALU_XOR:  Result = SrcA ^ SrcB;
      ALU_SLT:  Result = {{(XLEN-1){1'b0}}, ltSigned};
      ALU_SLTU: Result = {{(XLEN-1){1'b0}}, ltUnsigned};
      ALU_SLL:  Result = SrcA << SrcB[4:0];
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register with stall (hold) and bubble insertion.
module execute_cycle
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  execute_cycle_if.slave ex
);

  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] fwdBE;
  logic [XLEN-1:0] srcBE;
  logic [XLEN-1:0] aluResultE;
  logic            aluZero;
  logic            branchCond;
  exMem_t          exMem_reg;
  exMem_t          exMem_next;

  // FWD_M forwards the value already sitting in EX/MEM, so dependent
  // back-to-back ALU ops need no stall.
  assign srcAE = fwdSelect(ex.ForwardAE, ex.RD1E, ex.ResultW, exMem_reg.aluResult);
  assign fwdBE = fwdSelect(ex.ForwardBE, ex.RD2E, ex.ResultW, exMem_reg.aluResult);
  assign srcBE = ex.ALUSrcE ? ex.ImmExtE : fwdBE;

  alu u_alu (
    .SrcA       (srcAE),
    .SrcB       (srcBE),
    .ALUControl (ex.ALUControlE),
    .Result     (aluResultE),
    .Zero       (aluZero)
  );

  // Branches always compare the two register operands, never the immediate.
  always_comb begin
    branchCond = 1'b0;
    case (ex.Funct3E)
      F3_BEQ:  branchCond = (srcAE == fwdBE);
      F3_BNE:  branchCond = (srcAE != fwdBE);
      F3_BLT:  branchCond = ($signed(srcAE) <  $signed(fwdBE));
      F3_BGE:  branchCond = ($signed(srcAE) >= $signed(fwdBE));
      F3_BLTU: branchCond = (srcAE <  fwdBE);
      F3_BGEU: branchCond = (srcAE >= fwdBE);
      default: branchCond = 1'b0;
    endcase
  end

  assign ex.PCSrcE    = ex.ValidE & ex.BranchE & branchCond;
  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;

  // A bubble keeps its data fields but can never write anything downstream.
  always_comb begin
    exMem_next.valid     = ex.ValidE;
    exMem_next.regWrite  = ex.ValidE & ex.RegWriteE;
    exMem_next.resultSrc = ex.ValidE & ex.ResultSrcE;
    exMem_next.memWrite  = ex.ValidE & ex.MemWriteE;
    exMem_next.aluResult = aluResultE;
    exMem_next.writeData = fwdBE;
    exMem_next.pcPlus4   = ex.PCPlus4E;
    exMem_next.rd        = ex.RDE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exMem_reg <= '0;
    end else if (!ex.StallM) begin
      exMem_reg <= exMem_next;
    end
  end

  assign ex.ValidM     = exMem_reg.valid;
  assign ex.RegWriteM  = exMem_reg.regWrite;
  assign ex.ResultSrcM = exMem_reg.resultSrc;
  assign ex.MemWriteM  = exMem_reg.memWrite;
  assign ex.ALUResultM = exMem_reg.aluResult;
  assign ex.WriteDataM = exMem_reg.writeData;
  assign ex.PCPlus4M   = exMem_reg.pcPlus4;
  assign ex.RDM        = exMem_reg.rd;

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed scenarios plus randomized
// traffic compared against a behavioural model of the execute stage.
module tb_execute_cycle;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_cycle_if exIf ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (exIf.slave)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Model of the EX/MEM register as seen by the next stage.
  logic        mValid, mRegWrite, mResultSrc, mMemWrite;
  logic [31:0] mAlu, mWriteData, mPcPlus4;
  logic [4:0]  mRd;

  function automatic logic [104:0] expVec();
    return {mValid, mRegWrite, mResultSrc, mMemWrite, mAlu, mWriteData, mPcPlus4, mRd};
  endfunction

  function automatic logic [104:0] obsVec();
    return {exIf.ValidM, exIf.RegWriteM, exIf.ResultSrcM, exIf.MemWriteM,
            exIf.ALUResultM, exIf.WriteDataM, exIf.PCPlus4M, exIf.RDM};
  endfunction

  function automatic logic [31:0] refOperand(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return exIf.ResultW;
    if (sel == 2'd2) return mAlu;
    return rf;
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return a << b[4:0];
    endcase
  endfunction

  function automatic logic refTaken();
    logic [31:0] a, b;
    int signed sa, sb;
    logic c;
    a  = refOperand(exIf.ForwardAE, exIf.RD1E);
    b  = refOperand(exIf.ForwardBE, exIf.RD2E);
    sa = a;
    sb = b;
    case (exIf.Funct3E)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    return exIf.ValidE && exIf.BranchE && c;
  endfunction

  // Advance the model by one clock edge using the current inputs, then wait for it.
  task automatic tick();
    logic [31:0] a, b;
    if (rst) begin
      {mValid, mRegWrite, mResultSrc, mMemWrite} = 4'b0;
      {mAlu, mWriteData, mPcPlus4, mRd} = '0;
    end else if (!exIf.StallM) begin
      a = refOperand(exIf.ForwardAE, exIf.RD1E);
      b = refOperand(exIf.ForwardBE, exIf.RD2E);
      mAlu       = refAlu(exIf.ALUControlE, a, exIf.ALUSrcE ? exIf.ImmExtE : b);
      mWriteData = b;
      mPcPlus4   = exIf.PCPlus4E;
      mRd        = exIf.RDE;
      mValid     = exIf.ValidE;
      mRegWrite  = exIf.ValidE && exIf.RegWriteE;
      mResultSrc = exIf.ValidE && exIf.ResultSrcE;
      mMemWrite  = exIf.ValidE && exIf.MemWriteE;
    end
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%b stall=%b validM=%b aluM=%h wdM=%h rdM=%0d", txn, rst,
             exIf.StallM, exIf.ValidM, exIf.ALUResultM, exIf.WriteDataM, exIf.RDM);
  endtask

  task automatic clearInputs();
    exIf.ValidE = 1'b0; exIf.RegWriteE = 1'b0; exIf.ResultSrcE = 1'b0;
    exIf.MemWriteE = 1'b0; exIf.BranchE = 1'b0; exIf.ALUSrcE = 1'b0;
    exIf.ALUControlE = 3'd0; exIf.Funct3E = 3'd2;
    exIf.RD1E = '0; exIf.RD2E = '0; exIf.ImmExtE = '0; exIf.PCE = '0;
    exIf.PCPlus4E = '0; exIf.RDE = '0; exIf.ForwardAE = 2'd0; exIf.ForwardBE = 2'd0;
    exIf.ResultW = '0; exIf.StallM = 1'b0;
  endtask

  task automatic randomInputs();
    exIf.ValidE = 1'($urandom); exIf.RegWriteE = 1'($urandom);
    exIf.ResultSrcE = 1'($urandom); exIf.MemWriteE = 1'($urandom);
    exIf.BranchE = 1'($urandom); exIf.ALUSrcE = 1'($urandom);
    exIf.ALUControlE = 3'($urandom); exIf.Funct3E = 3'($urandom);
    exIf.RD1E = $urandom; exIf.RD2E = $urandom; exIf.ImmExtE = $urandom;
    exIf.PCE = $urandom; exIf.PCPlus4E = $urandom; exIf.RDE = 5'($urandom);
    exIf.ForwardAE = 2'($urandom); exIf.ForwardBE = 2'($urandom);
    exIf.ResultW = $urandom;
  endtask

  task automatic setAdd(input logic [31:0] a, input logic [31:0] b);
    clearInputs();
    exIf.ValidE = 1'b1; exIf.RegWriteE = 1'b1; exIf.ALUControlE = ALU_ADD;
    exIf.RD1E = a; exIf.RD2E = b; exIf.RDE = 5'd3; exIf.PCPlus4E = 32'h44;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      randomInputs();
      exIf.StallM = 1'($urandom);
      tick();
      checks++;
      if (obsVec() !== 105'd0) begin
        failures++;
        $display("FAIL reset_clear: got %h required 0", obsVec());
      end
    end
    rst = 1'b0;
    setAdd(32'd5, 32'd7);
    tick();
    checks++;
    if ({exIf.ALUResultM, exIf.RegWriteM, exIf.ValidM} !== {32'd12, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_first_add: got alu=%h rw=%b v=%b required alu=0000000c rw=1 v=1",
               exIf.ALUResultM, exIf.RegWriteM, exIf.ValidM);
    end
  endtask

  task automatic test_forwarding();
    setAdd(32'd5, 32'd7);
    tick();
    checks++;
    if (exIf.ALUResultM !== 32'd12) begin
      failures++;
      $display("FAIL fwd_setup: got %h required 0000000c", exIf.ALUResultM);
    end
    clearInputs();
    exIf.ValidE = 1'b1; exIf.RegWriteE = 1'b1; exIf.ALUControlE = ALU_SUB;
    exIf.ForwardAE = FWD_M; exIf.RD1E = 32'hDEADBEEF; exIf.RD2E = 32'd20;
    tick();
    checks++;
    if (exIf.ALUResultM !== 32'hFFFFFFF8) begin
      failures++;
      $display("FAIL fwd_mem_a: got %h required fffffff8", exIf.ALUResultM);
    end
    clearInputs();
    exIf.ValidE = 1'b1; exIf.MemWriteE = 1'b1; exIf.ALUControlE = ALU_ADD;
    exIf.ForwardBE = FWD_W; exIf.ResultW = 32'd3; exIf.RD1E = 32'd10;
    exIf.RD2E = 32'h12345678;
    tick();
    checks++;
    if ({exIf.WriteDataM, exIf.ALUResultM} !== {32'd3, 32'd13}) begin
      failures++;
      $display("FAIL fwd_wb_b: got wd=%h alu=%h required wd=00000003 alu=0000000d",
               exIf.WriteDataM, exIf.ALUResultM);
    end
    checks++;
    if (obsVec() !== expVec()) begin
      failures++;
      $display("FAIL fwd_model: got %h required %h", obsVec(), expVec());
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3Tab [4] = '{F3_BLT, F3_BLTU, F3_BNE, F3_BEQ};
    logic [31:0] aTab  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'd9};
    logic [31:0] bTab  [4] = '{32'd1, 32'd1, 32'd9, 32'd9};
    logic        vTab  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        tTab  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      clearInputs();
      exIf.ValidE = vTab[i]; exIf.BranchE = 1'b1; exIf.Funct3E = f3Tab[i];
      exIf.ALUControlE = ALU_SUB; exIf.PCE = 32'h100; exIf.ImmExtE = 32'hFFFFFFF0;
      exIf.ALUSrcE = 1'b1; exIf.RD1E = aTab[i]; exIf.RD2E = bTab[i];
      #1;
      checks++;
      if ({exIf.PCSrcE, exIf.PCTargetE} !== {tTab[i], 32'hF0}) begin
        failures++;
        $display("FAIL branch_%0d: got taken=%b target=%h required taken=%b target=000000f0",
                 i, exIf.PCSrcE, exIf.PCTargetE, tTab[i]);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [104:0] held;
    setAdd(32'h1000, 32'h234);
    tick();
    held = obsVec();
    exIf.StallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomInputs();
      exIf.ValidE = 1'b1;
      exIf.StallM = 1'b1;
      tick();
      checks++;
      if (obsVec() !== held || expVec() !== held) begin
        failures++;
        $display("FAIL stall_hold_%0d: got %h required %h", i, obsVec(), held);
      end
    end
    randomInputs();
    exIf.ValidE = 1'b1;
    exIf.StallM = 1'b0;
    tick();
    checks++;
    if (obsVec() !== expVec()) begin
      failures++;
      $display("FAIL stall_release: got %h required %h", obsVec(), expVec());
    end
  endtask

  task automatic test_bubble();
    clearInputs();
    exIf.ValidE = 1'b0; exIf.RegWriteE = 1'b1; exIf.MemWriteE = 1'b1;
    exIf.ResultSrcE = 1'b1; exIf.BranchE = 1'b1; exIf.Funct3E = F3_BEQ;
    exIf.RD1E = 32'd77; exIf.RD2E = 32'd77; exIf.RDE = 5'd9;
    #1;
    checks++;
    if (exIf.PCSrcE !== 1'b0) begin
      failures++;
      $display("FAIL bubble_branch: got %b required 0", exIf.PCSrcE);
    end
    tick();
    checks++;
    if ({exIf.ValidM, exIf.RegWriteM, exIf.MemWriteM, exIf.ResultSrcM} !== 4'b0000 ||
        obsVec() !== expVec()) begin
      failures++;
      $display("FAIL bubble_capture: got %h required %h", obsVec(), expVec());
    end
  endtask

  task automatic test_reset_priority();
    setAdd(32'd5, 32'd7);
    tick();
    checks++;
    if (obsVec() === 105'd0) begin
      failures++;
      $display("FAIL rstprio_setup: got all-zero required nonzero");
    end
    rst = 1'b1;
    exIf.StallM = 1'b1;
    tick();
    checks++;
    if (obsVec() !== 105'd0) begin
      failures++;
      $display("FAIL rstprio_clear: got %h required 0", obsVec());
    end
    rst = 1'b0;
    exIf.StallM = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      randomInputs();
      exIf.StallM = ($urandom_range(3) == 0);
      rst = ($urandom_range(15) == 0);
      #1;
      checks++;
      if ({exIf.PCSrcE, exIf.PCTargetE} !== {refTaken(), exIf.PCE + exIf.ImmExtE}) begin
        failures++;
        $display("FAIL rand_branch_%0d: got taken=%b target=%h required taken=%b target=%h",
                 i, exIf.PCSrcE, exIf.PCTargetE, refTaken(), exIf.PCE + exIf.ImmExtE);
      end
      tick();
      checks++;
      if (obsVec() !== expVec()) begin
        failures++;
        $display("FAIL rand_exmem_%0d: got %h required %h", i, obsVec(), expVec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    test_reset();
    test_forwarding();
    test_branch();
    test_stall();
    test_bubble();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
